// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and helpers for the demux_router slice.
//   DATA_W  - data path width
//   NUM_CH  - number of output channels (legal select 0..NUM_CH-1)
//   SEL_W   - width of the channel select
//   CNT_W   - width of the saturating drop counter
//   CNT_MAX - saturation value of the drop counter
package demux_pkg;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 9;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // True when the select addresses an existing channel.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return (sel < SEL_W'(NUM_CH));
  endfunction

endpackage

// File: rtl/demux_router_if.sv
// demux_router_if: bundles the input valid/ready stream, the per-channel
// output handshakes and the drop status of the demux_router.
//   in_valid/in_ready/in_data/in_sel - input beat handshake and payload
//   out_valid/out_ready/out_data     - per-channel handshakes, channel k at
//                                      out_data[k*DATA_W +: DATA_W]
//   drop_pulse/drop_cnt              - drop indication and saturating count
// Modports: slave is the router side, master is the source/consumer side.
interface demux_router_if;
  import demux_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     drop_pulse;
  logic [CNT_W-1:0]         drop_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, clears valid and data
//   load  - a beat for this channel is accepted this cycle
//   drain - consumer takes the held beat this cycle (out_ready)
//   din   - incoming beat
//   valid - slot holds a beat
//   data  - held beat; keeps its value until the next load
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  // Load takes priority over drain: a simultaneous load and drain replaces
  // the held beat and keeps valid high, giving one beat per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_router.sv
// demux_router: registered 1-to-NUM_CH demultiplexer. Steers each accepted
// input beat into the holding register of the selected channel; beats with
// a select outside 0..NUM_CH-1 are consumed, dropped and counted.
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - demux_router_if.slave (input stream, channel outputs, drop status)
module demux_router
  import demux_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  demux_router_if.slave  bus
);

  logic [NUM_CH-1:0]        sel_hot;
  logic [NUM_CH-1:0]        slot_free;
  logic [NUM_CH-1:0]        load;
  logic [NUM_CH-1:0]        valid_q;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic                     legal;
  logic                     ready;
  logic                     fire;
  logic                     drop_fire;
  logic                     drop_pulse_q;
  logic [CNT_W-1:0]         drop_cnt_q;

  always_comb begin
    sel_hot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hot[k] = (bus.in_sel == SEL_W'(k));
    end
  end

  assign legal     = sel_legal(bus.in_sel);
  // A slot can take a beat when empty or when it is being drained this cycle.
  assign slot_free = ~valid_q | bus.out_ready;
  // Illegal selects are always accepted so they can be discarded.
  assign ready     = !rst && (!legal || |(sel_hot & slot_free));
  assign fire      = bus.in_valid && ready;
  assign load      = sel_hot & {NUM_CH{fire}};
  assign drop_fire = fire && !legal;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .drain (bus.out_ready[k]),
      .din   (bus.in_data),
      .valid (valid_q[k]),
      .data  (data_q[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_fire;
      if (drop_fire && (drop_cnt_q != CNT_MAX)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_router_if bus ();

  demux_router dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel occupancy and content, drop status.
  bit   [NUM_CH-1:0] exp_valid;
  logic [DATA_W-1:0] exp_data [NUM_CH];
  int                exp_cnt;
  bit                exp_pulse;
  bit                last_fire;

  function automatic bit model_ready();
    int s;
    s = int'(bus.in_sel);
    if (rst) return 1'b0;
    if (s >= NUM_CH) return 1'b1;
    return !exp_valid[s] || bus.out_ready[s];
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] exp_bus();
    logic [NUM_CH*DATA_W-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k*DATA_W +: DATA_W] = exp_data[k];
    return v;
  endfunction

  task automatic model_clear();
    exp_valid = '0;
    for (int k = 0; k < NUM_CH; k++) exp_data[k] = '0;
    exp_cnt   = 0;
    exp_pulse = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [SEL_W-1:0] s,
                       input logic [DATA_W-1:0] d, input logic [NUM_CH-1:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
  endtask

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    bit fire;
    int s;
    bit [NUM_CH-1:0] nv;
    s    = int'(bus.in_sel);
    fire = bus.in_valid && model_ready();
    nv   = exp_valid;
    for (int k = 0; k < NUM_CH; k++) begin
      if (fire && s == k) nv[k] = 1'b1;
      else if (exp_valid[k] && bus.out_ready[k]) nv[k] = 1'b0;
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < NUM_CH; k++) if (fire && s == k) exp_data[k] = bus.in_data;
      exp_valid = nv;
      exp_pulse = fire && (s >= NUM_CH);
      if (exp_pulse && exp_cnt < 255) exp_cnt++;
    end
    last_fire = fire;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd2, 16'hBEEF, '0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
    end
    repeat (3) tick();
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'h0, '0);
    checks++;
    if (bus.out_valid !== '0 || bus.out_data !== '0) begin
      errors++; $display("FAIL reset_outputs got valid %b data %h want 0", bus.out_valid, bus.out_data);
    end
    checks++;
    if (bus.drop_pulse !== 1'b0 || bus.drop_cnt !== '0) begin
      errors++; $display("FAIL reset_drop got pulse %b cnt %0d want 0 0", bus.drop_pulse, bus.drop_cnt);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 4'd3, 16'hA5A5, '0);
    tick();
    drive(1'b0, 4'd3, 16'hA5A5, '0);
    checks++;
    if (bus.out_valid !== 9'b000001000) begin
      errors++; $display("FAIL basic_valid got %b want 000001000", bus.out_valid);
    end
    checks++;
    if (bus.out_data[3*DATA_W +: DATA_W] !== 16'hA5A5) begin
      errors++; $display("FAIL basic_data got %h want a5a5", bus.out_data[3*DATA_W +: DATA_W]);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 4'd3, 16'h5555, '0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_ready got %b want 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_data[3*DATA_W +: DATA_W] !== 16'hA5A5 || bus.out_valid[3] !== 1'b1) begin
      errors++; $display("FAIL stall_hold got %h want a5a5", bus.out_data[3*DATA_W +: DATA_W]);
    end
    drive(1'b1, 4'd5, 16'h0F0F, '0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_other_ready got %b want 1", bus.in_ready);
    end
    tick();
    drive(1'b0, 4'd0, 16'h0, '0);
    checks++;
    if (bus.out_valid !== 9'b000101000 || bus.out_data !== exp_bus()) begin
      errors++; $display("FAIL stall_other_land got %b want 000101000", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    drive(1'b1, 4'd2, 16'h1111, '0);
    tick();
    for (int i = 0; i < 10; i++) begin
      d = (i == 0) ? 16'h1234 : DATA_W'($urandom);
      drive(1'b1, 4'd2, d, 9'b000000100);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready beat %0d got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid[2] !== 1'b1 || bus.out_data[2*DATA_W +: DATA_W] !== d) begin
        errors++; $display("FAIL b2b_data beat %0d got %b/%h want 1/%h", i, bus.out_valid[2],
                           bus.out_data[2*DATA_W +: DATA_W], d);
      end
    end
    drive(1'b0, 4'd0, 16'h0, '1);
    tick();
  endtask

  task automatic test_drop();
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0, '0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 4'hF, DATA_W'($urandom), NUM_CH'($urandom));
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL drop_ready beat %0d got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.drop_pulse !== 1'b1 || int'(bus.drop_cnt) !== ((i > 255) ? 255 : i)) begin
        errors++; $display("FAIL drop_cnt beat %0d got pulse %b cnt %0d want 1 %0d", i,
                           bus.drop_pulse, bus.drop_cnt, (i > 255) ? 255 : i);
      end
      checks++;
      if (bus.out_valid !== '0) begin
        errors++; $display("FAIL drop_valid beat %0d got %b want 0", i, bus.out_valid);
      end
    end
    drive(1'b0, 4'd0, 16'h0, '0);
    tick();
    checks++;
    if (bus.drop_pulse !== 1'b0 || bus.drop_cnt !== 8'd255) begin
      errors++; $display("FAIL drop_end got pulse %b cnt %0d want 0 255", bus.drop_pulse, bus.drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd0, 16'hC000, '0); tick();
    drive(1'b1, 4'd4, 16'hC004, '0); tick();
    drive(1'b1, 4'd8, 16'hC008, '0); tick();
    drive(1'b1, 4'd1, 16'hC001, '0);
    checks++;
    if (bus.out_valid !== 9'b100010001) begin
      errors++; $display("FAIL rmid_fill got %b want 100010001", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_ready got %b want 0", bus.in_ready);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 4'd1, 16'hC001, '0);
    checks++;
    if (bus.out_valid !== '0 || bus.out_data !== '0 || bus.drop_cnt !== '0 || bus.drop_pulse !== 1'b0) begin
      errors++; $display("FAIL rmid_clear got valid %b data %h cnt %0d want all 0",
                         bus.out_valid, bus.out_data, bus.drop_cnt);
    end
    tick();
    checks++;
    if (bus.out_valid !== '0) begin
      errors++; $display("FAIL rmid_nocapture got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [SEL_W-1:0]  s;
    logic [DATA_W-1:0] d;
    bit                v;
    v = 1'b0; s = '0; d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(v && !last_fire)) begin
        v = ($urandom_range(0, 3) != 0);
        s = SEL_W'($urandom_range(0, 10));
        if (s == 4'd10) s = SEL_W'($urandom_range(9, 15));
        d = DATA_W'($urandom);
      end
      drive(v, s, d, NUM_CH'($urandom));
      checks++;
      if (bus.in_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b want %b", i, bus.in_ready, model_ready());
      end
      last_fire = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== exp_valid || bus.out_data !== exp_bus()) begin
        errors++; $display("FAIL rand_out cycle %0d got %b %h want %b %h", i,
                           bus.out_valid, bus.out_data, exp_valid, exp_bus());
      end
      checks++;
      if (bus.drop_pulse !== exp_pulse || int'(bus.drop_cnt) !== exp_cnt) begin
        errors++; $display("FAIL rand_drop cycle %0d got %b %0d want %b %0d", i,
                           bus.drop_pulse, bus.drop_cnt, exp_pulse, exp_cnt);
      end
    end
  endtask

  initial begin
    model_clear();
    last_fire = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
